// File: rtl/mips_exc_pkg.sv
// Shared definitions for the exception commit path: ExcCodes, flag bit positions, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_exc_pkg;

  // Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bit positions inside m_exc; a higher index means a higher priority
  localparam int EXC_FLAG_W   = 9;
  localparam int BIT_ADEL_IF  = 8;
  localparam int BIT_TLBL_IF  = 7;
  localparam int BIT_RI       = 6;
  localparam int BIT_OV       = 5;
  localparam int BIT_SYS      = 4;
  localparam int BIT_BP       = 3;
  localparam int BIT_ADEL_D   = 2;
  localparam int BIT_ADES_D   = 1;
  localparam int BIT_TLB_D    = 0;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Source of the BadVAddr value for the winning exception
  typedef enum logic [1:0] {
    BVA_NONE = 2'd0,
    BVA_PC   = 2'd1,
    BVA_DATA = 2'd2
  } bva_sel_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXC   = 2'd1,
    S_ERET  = 2'd2,
    S_REDIR = 2'd3
  } exc_state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: exception flags plus pending interrupt -> ExcCode, BadVAddr source, hit.
// Latency: combinational.
// Backpressure: none.
// Ports: exc (flag vector, bit8 highest), int_pend, tlb_store (TLBS vs TLBL for tlb_d)
//        -> hit, exccode, bva_sel.
module exc_prio_enc
  import mips_exc_pkg::*;
(
  input  logic [EXC_FLAG_W-1:0] exc,
  input  logic                  int_pend,
  input  logic                  tlb_store,
  output logic                  hit,
  output logic [4:0]            exccode,
  output bva_sel_t              bva_sel
);

  always_comb begin
    hit     = 1'b1;
    exccode = EXC_INT;
    bva_sel = BVA_NONE;
    if (int_pend) begin
      exccode = EXC_INT;
    end else if (exc[BIT_ADEL_IF]) begin
      exccode = EXC_ADEL;
      bva_sel = BVA_PC;
    end else if (exc[BIT_TLBL_IF]) begin
      exccode = EXC_TLBL;
      bva_sel = BVA_PC;
    end else if (exc[BIT_RI]) begin
      exccode = EXC_RI;
    end else if (exc[BIT_OV]) begin
      exccode = EXC_OV;
    end else if (exc[BIT_SYS]) begin
      exccode = EXC_SYS;
    end else if (exc[BIT_BP]) begin
      exccode = EXC_BP;
    end else if (exc[BIT_ADEL_D]) begin
      exccode = EXC_ADEL;
      bva_sel = BVA_DATA;
    end else if (exc[BIT_ADES_D]) begin
      exccode = EXC_ADES;
      bva_sel = BVA_DATA;
    end else if (exc[BIT_TLB_D]) begin
      exccode = tlb_store ? EXC_TLBS : EXC_TLBL;
      bva_sel = BVA_DATA;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt commit controller: turns a committing instruction's exception, pending
// interrupt or ERET into a cp0 update / EXL clear, a pipeline flush and a fetch redirect.
// Latency: commit at N -> cp0 strobe + flush at N+1 -> redirect_valid from N+2.
// Backpressure: redirect_valid/redirect_pc held until redirect_ready; commits ignored meanwhile.
// Ports: clk, rst (async active-low); m_* memory-stage commit info; cp0_has_int/cp0_epc from cp0;
//        w_cp0_* exception write port to cp0; cp0_cls_exl; flush; redirect valid/ready/pc.
module exc_ctrl
  import mips_exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int          FLAG_W     = EXC_FLAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_stall,
  input  logic [31:0]       m_pc,
  input  logic              m_in_ds,
  input  logic [FLAG_W-1:0] m_exc,
  input  logic              m_tlb_store,
  input  logic [31:0]       m_badvaddr,
  input  logic              m_eret,
  input  logic              cp0_has_int,
  input  logic [31:0]       cp0_epc,
  output logic              w_cp0_update_ena,
  output logic [4:0]        w_cp0_exccode,
  output logic              w_cp0_bd,
  output logic              w_cp0_exl,
  output logic [31:0]       w_cp0_epc,
  output logic              w_cp0_badvaddr_ena,
  output logic [31:0]       w_cp0_badvaddr,
  output logic              cp0_cls_exl,
  output logic              flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  input  logic              redirect_ready
);

  exc_state_t state, state_nxt;
  logic       int_pend;
  logic       commit;
  logic       take_exc;
  logic       hit;
  logic [4:0] enc_exccode;
  bva_sel_t   enc_bva_sel;

  exc_prio_enc u_prio (
    .exc       (m_exc),
    .int_pend  (int_pend),
    .tlb_store (m_tlb_store),
    .hit       (hit),
    .exccode   (enc_exccode),
    .bva_sel   (enc_bva_sel)
  );

  // Only IDLE accepts commits; anything arriving while flushing is a squashed instruction.
  assign commit   = m_valid & ~m_stall & (state == S_IDLE);
  assign take_exc = commit & hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (take_exc)            state_nxt = S_EXC;
        else if (commit & m_eret) state_nxt = S_ERET;
      end
      S_EXC:   state_nxt = S_REDIR;
      S_ERET:  state_nxt = S_REDIR;
      S_REDIR: if (redirect_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are flops keyed off the next state so each is valid for exactly the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_pend           <= 1'b0;
      w_cp0_update_ena   <= 1'b0;
      w_cp0_exccode      <= '0;
      w_cp0_bd           <= 1'b0;
      w_cp0_exl          <= 1'b0;
      w_cp0_epc          <= '0;
      w_cp0_badvaddr_ena <= 1'b0;
      w_cp0_badvaddr     <= '0;
      cp0_cls_exl        <= 1'b0;
      flush              <= 1'b0;
      redirect_valid     <= 1'b0;
      redirect_pc        <= '0;
    end else begin
      int_pend           <= cp0_has_int;
      w_cp0_update_ena   <= take_exc;
      w_cp0_exl          <= take_exc;
      w_cp0_badvaddr_ena <= take_exc & (enc_bva_sel != BVA_NONE);
      cp0_cls_exl        <= (state_nxt == S_ERET);
      flush              <= (state_nxt == S_EXC) | (state_nxt == S_ERET);
      redirect_valid     <= (state_nxt == S_REDIR);

      if (take_exc) begin
        w_cp0_exccode <= enc_exccode;
        w_cp0_bd      <= m_in_ds;
        // Delay-slot faults restart at the branch so it re-executes; wraps at zero.
        w_cp0_epc     <= m_in_ds ? (m_pc - 32'd4) : m_pc;
        if (enc_bva_sel == BVA_PC)        w_cp0_badvaddr <= m_pc;
        else if (enc_bva_sel == BVA_DATA) w_cp0_badvaddr <= m_badvaddr;
      end

      // EPC is read in the ERET cycle, not at commit, so an mtc0 EPC just ahead of the eret is seen.
      if (state == S_EXC)       redirect_pc <= EXC_VECTOR;
      else if (state == S_ERET) redirect_pc <= cp0_epc;
    end
  end

endmodule
